// File: rtl/vedic_seq_mul.sv
// rtl/vedic_seq_mul.sv - iterative WIDTH x WIDTH unsigned multiplier over one 2-bit Vedic core

// 2x2 Vedic (Urdhva-Tiryagbhyam) multiplier core: purely combinational.
module vedic_2bit (
  input  logic [1:0] i_a,
  input  logic [1:0] i_b,
  output logic [3:0] o_q
);
  logic w_cross0;
  logic w_cross1;
  logic w_carry1;

  assign w_cross0 = i_a[1] & i_b[0];
  assign w_cross1 = i_a[0] & i_b[1];
  assign w_carry1 = w_cross0 & w_cross1;

  assign o_q[0] = i_a[0] & i_b[0];
  assign o_q[1] = w_cross0 ^ w_cross1;
  assign o_q[2] = (i_a[1] & i_b[1]) ^ w_carry1;
  assign o_q[3] = (i_a[1] & i_b[1]) & w_carry1;
endmodule

// Operand sequencer: walks digit pairs (i outer, j inner) through the core and accumulates.
module vedic_seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);
  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [2*WIDTH-1:0]   r_acc;
  logic [IW-1:0]        r_i;
  logic [IW-1:0]        r_j;

  logic [1:0]           w_a_dig;
  logic [1:0]           w_b_dig;
  logic [3:0]           w_q;
  logic [IW:0]          w_dsum;
  logic [IW+1:0]        w_shamt;
  logic [2*WIDTH-1:0]   w_pp_sh;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic                 w_last;
  logic                 w_accept;

  // Current digit pair: digit k of an operand sits at bits [2k+1:2k].
  assign w_a_dig = 2'(r_a >> {r_i, 1'b0});
  assign w_b_dig = 2'(r_b >> {r_j, 1'b0});

  vedic_2bit u_core (
    .i_a (w_a_dig),
    .i_b (w_b_dig),
    .o_q (w_q)
  );

  // Partial product weight is 4^(i+j), i.e. a left shift by 2*(i+j).
  assign w_dsum    = {1'b0, r_i} + {1'b0, r_j};
  assign w_shamt   = {w_dsum, 1'b0};
  assign w_pp_sh   = (2*WIDTH)'(w_q) << w_shamt;
  assign w_acc_nxt = r_acc + w_pp_sh;
  assign w_last    = (r_i == LAST) && (r_j == LAST);
  assign w_accept  = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = S_CALC;
      end
      S_CALC: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, digit counters, accumulator and registered product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      product <= '0;
    end else if (r_state == S_IDLE) begin
      if (w_accept) begin
        r_a   <= a;
        r_b   <= b;
        r_acc <= '0;
        r_i   <= '0;
        r_j   <= '0;
      end
    end else if (r_state == S_CALC) begin
      r_acc <= w_acc_nxt;
      if (w_last) begin
        product <= w_acc_nxt;
      end else if (r_j == LAST) begin
        r_j <= '0;
        r_i <= r_i + IW'(1);
      end else begin
        r_j <= r_j + IW'(1);
      end
    end
  end
endmodule
